// File: rtl/hub_fold_seq.sv
// Control sequencer for the folded hybrid-unary linear stage.
// Walks CLEAR -> (LOAD -> RUN x BLEN) x FOLD -> DONE, producing the
// clear/load/sel/part control stream plus a bitstream cycle index.
module hub_fold_seq #(
    parameter int IDIM = 256,
    parameter int SDIM = 32,
    parameter int RWID = 10,
    parameter int FOLD = (IDIM / SDIM < 1) ? 1 : IDIM / SDIM,
    parameter int PWID = (FOLD < 2) ? 1 : $clog2(FOLD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            hold,
    input  logic            abort,
    output logic            load,
    output logic            sel,
    output logic            clear,
    output logic [PWID-1:0] part,
    output logic [RWID-1:0] rIdx,
    output logic            busy,
    output logic            done
);

    localparam logic [PWID-1:0] PART_LAST = PWID'(FOLD - 1);
    localparam logic [RWID-1:0] RIDX_LAST = {RWID{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [PWID-1:0] part_reg, part_next;
    logic [RWID-1:0] ridx_reg, ridx_next;
    logic            load_reg, sel_reg, clear_reg, busy_reg, done_reg;

    // Next-state, partition and bitstream-index logic; abort beats hold beats start.
    always_comb begin
        state_next = state_reg;
        part_next  = part_reg;
        ridx_next  = ridx_reg;
        if (abort) begin
            // Abort in IDLE is a no-op and also swallows a coincident start.
            if (state_reg != ST_IDLE) begin
                state_next = ST_IDLE;
                part_next  = '0;
                ridx_next  = '0;
            end
        end else if (!hold) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_CLEAR;
                        part_next  = '0;
                        ridx_next  = '0;
                    end
                end
                ST_CLEAR: begin
                    state_next = ST_LOAD;
                    part_next  = '0;
                    ridx_next  = '0;
                end
                ST_LOAD: begin
                    state_next = ST_RUN;
                    ridx_next  = '0;
                end
                ST_RUN: begin
                    if (ridx_reg == RIDX_LAST) begin
                        ridx_next = '0;
                        if (part_reg == PART_LAST) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_LOAD;
                            part_next  = part_reg + 1'b1;
                        end
                    end else begin
                        ridx_next = ridx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                    part_next  = '0;
                    ridx_next  = '0;
                end
                default: begin
                    state_next = ST_IDLE;
                    part_next  = '0;
                    ridx_next  = '0;
                end
            endcase
        end
    end

    // State, counters and decoded control outputs all registered together,
    // so a held cycle freezes every output including the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            part_reg  <= '0;
            ridx_reg  <= '0;
            load_reg  <= 1'b0;
            sel_reg   <= 1'b0;
            clear_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            part_reg  <= part_next;
            ridx_reg  <= ridx_next;
            load_reg  <= (state_next == ST_LOAD);
            sel_reg   <= (state_next == ST_RUN);
            clear_reg <= (state_next == ST_CLEAR);
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    assign load  = load_reg;
    assign sel   = sel_reg;
    assign clear = clear_reg;
    assign part  = part_reg;
    assign rIdx  = ridx_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_hub_fold_seq.sv
// Scoreboard bench for hub_fold_seq (FOLD=2, BLEN=4). The reference model
// tracks only "evaluation active" and "unstalled cycles since start", and
// derives every expected output from that with plain arithmetic.
module tb_hub_fold_seq;

    localparam int IDIM  = 64;
    localparam int SDIM  = 32;
    localparam int RWID  = 2;
    localparam int FOLD  = (IDIM / SDIM < 1) ? 1 : IDIM / SDIM;
    localparam int PWID  = (FOLD < 2) ? 1 : $clog2(FOLD);
    localparam int BLEN  = 1 << RWID;
    // Cycle offset (from the clear cycle) at which done appears.
    localparam int TOTAL = 1 + FOLD * (1 + BLEN);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, hold, abort;
    logic            load, sel, clear, busy, done;
    logic [PWID-1:0] part;
    logic [RWID-1:0] rIdx;

    typedef struct packed {
        logic            load;
        logic            sel;
        logic            clear;
        logic            busy;
        logic            done;
        logic [PWID-1:0] part;
        logic [RWID-1:0] ridx;
        logic            pr_care;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   dones  = 0;

    // Model state: evaluation in progress, and cycles elapsed since its clear cycle.
    bit   m_act = 1'b0;
    int   m_t   = 0;

    hub_fold_seq #(.IDIM(IDIM), .SDIM(SDIM), .RWID(RWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .hold  (hold),
        .abort (abort),
        .load  (load),
        .sel   (sel),
        .clear (clear),
        .part  (part),
        .rIdx  (rIdx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given point in an evaluation.
    function automatic exp_t model_out(bit act, int t);
        exp_t e;
        int   phase;
        int   q;
        e = '0;
        e.pr_care = 1'b1;
        if (act) begin
            e.busy = 1'b1;
            if (t == 0) begin
                e.clear = 1'b1;
            end else if (t == TOTAL) begin
                e.done    = 1'b1;
                e.pr_care = 1'b0;
            end else begin
                phase  = t - 1;
                q      = phase % (1 + BLEN);
                e.part = PWID'(phase / (1 + BLEN));
                if (q == 0) begin
                    e.load = 1'b1;
                end else begin
                    e.sel  = 1'b1;
                    e.ridx = RWID'(q - 1);
                end
            end
        end
        return e;
    endfunction

    // One clock of stimulus: drive inputs, let the DUT sample, advance the model.
    task automatic drive(input bit st, input bit hd, input bit ab);
        start = st;
        hold  = hd;
        abort = ab;
        @(posedge clk);
        if (!rst_n) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (m_act) begin
            if (ab) begin
                m_act = 1'b0;
            end else if (!hd) begin
                if (m_t == TOTAL) m_act = 1'b0;
                else m_t++;
            end
        end else if (st && !hd && !ab) begin
            m_act = 1'b1;
            m_t   = 0;
        end
        exp_q.push_back(model_out(m_act, m_t));
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle with a pending expectation, compare the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{load: load, sel: sel, clear: clear, busy: busy, done: done,
                  part: part, ridx: rIdx, pr_care: e.pr_care};
            if (!e.pr_care) begin
                a.part = '0;
                a.ridx = '0;
            end
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d outputs: got load=%b sel=%b clear=%b busy=%b done=%b part=%0d rIdx=%0d, want load=%b sel=%b clear=%b busy=%b done=%b part=%0d rIdx=%0d",
                         cyc, a.load, a.sel, a.clear, a.busy, a.done, a.part, a.ridx,
                         e.load, e.sel, e.clear, e.busy, e.done, e.part, e.ridx);
            end else if (e.done) begin
                dones++;
                $display("txn %0d: evaluation done at cycle %0d", dones, cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({load, sel, clear, busy, done, part, rIdx} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b, want all zero",
                     {load, sel, clear, busy, done, part, rIdx});
        end
        rst_n = 1'b1;

        // Nominal evaluation, then idle past done.
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(14);

        // Hold for three cycles while rIdx=1 of part 0.
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(3);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        idle_cycles(12);

        // start at cycle 5 and in the DONE cycle ignored; start at 13 accepted.
        drive(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 13; c++) drive(c == 5 || c == 12 || c == 13, 1'b0, 1'b0);
        idle_cycles(14);

        // Abort during RUN of part 1; abort in IDLE with start is a no-op.
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(8);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        idle_cycles(3);

        // Hold has priority over start in IDLE; abort over hold mid-run.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        drive(1'b0, 1'b1, 1'b1);
        idle_cycles(2);

        // Asynchronous reset mid-RUN, then a fresh evaluation.
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({load, sel, clear, busy, done, part, rIdx} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b, want all zero before next edge",
                     {load, sel, clear, busy, done, part, rIdx});
        end
        exp_q.delete();
        m_act = 1'b0;
        m_t   = 0;
        exp_q.push_back(model_out(1'b0, 0));
        idle_cycles(2);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        idle_cycles(14);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
        end
        idle_cycles(14);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
